buyruk_blok_doldurucu: RTL and testbench

Instruction-cache refill engine, directly downstream of the instruction cache controller on its main-memory read port. It accepts one block-read request, fetches the block as BLOK_KELIME sequential word reads over a word-wide memory bus with a valid/ready handshake, and returns the assembled block with a one-cycle ready pulse. A per-word timeout reports a memory bus that has stopped responding.

---
 rtl/buyruk_blok_doldurucu_if.sv | 32 +++
 rtl/buyruk_blok_doldurucu.sv | 119 +++++++++++
 tb/tb_buyruk_blok_doldurucu.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/buyruk_blok_doldurucu_if.sv
// Request-side and memory-side signals of the instruction-cache refill engine.
// The engine connects through the slave modport; the cache controller/memory side uses master.
interface buyruk_blok_doldurucu_if #(
  parameter int ADRES_BIT   = 32,
  parameter int VERI_BIT    = 32,
  parameter int BLOK_KELIME = 4
);
  logic [ADRES_BIT-1:0]            okuma_istek_adres_i;
  logic                            okuma_istek_gecerli_i;
  logic [VERI_BIT*BLOK_KELIME-1:0] okuma_veri_blok_o;
  logic                            okuma_istek_hazir_o;
  logic                            hata_o;
  logic [ADRES_BIT-1:0]            bellek_istek_adres_o;
  logic                            bellek_istek_gecerli_o;
  logic                            bellek_istek_hazir_i;
  logic [VERI_BIT-1:0]             bellek_veri_i;
  logic                            bellek_veri_gecerli_i;

  modport slave (
    input  okuma_istek_adres_i, okuma_istek_gecerli_i,
    input  bellek_istek_hazir_i, bellek_veri_i, bellek_veri_gecerli_i,
    output okuma_veri_blok_o, okuma_istek_hazir_o, hata_o,
    output bellek_istek_adres_o, bellek_istek_gecerli_o
  );

  modport master (
    output okuma_istek_adres_i, okuma_istek_gecerli_i,
    output bellek_istek_hazir_i, bellek_veri_i, bellek_veri_gecerli_i,
    input  okuma_veri_blok_o, okuma_istek_hazir_o, hata_o,
    input  bellek_istek_adres_o, bellek_istek_gecerli_o
  );
endinterface

// File: rtl/buyruk_blok_doldurucu.sv
// Instruction-cache refill engine: fetches one block as sequential word reads
// with a single outstanding memory transaction and a per-word timeout.
module buyruk_blok_doldurucu #(
  parameter int ADRES_BIT   = 32,
  parameter int VERI_BIT    = 32,
  parameter int BLOK_KELIME = 4,
  parameter int ZAMAN_ASIMI = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  buyruk_blok_doldurucu_if.slave bus
);

  localparam int BLOK_BIT        = VERI_BIT * BLOK_KELIME;
  localparam int KELIME_BAYT_BIT = $clog2(VERI_BIT / 8);
  localparam int BLOK_BAYT_BIT   = $clog2(BLOK_KELIME * VERI_BIT / 8);
  localparam int KB              = (BLOK_KELIME > 1) ? $clog2(BLOK_KELIME) : 1;
  localparam int SB              = (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI) : 1;

  localparam logic [KB-1:0] SON_KELIME = KB'(BLOK_KELIME - 1);
  localparam logic [SB-1:0] SAYAC_SON  = SB'((ZAMAN_ASIMI > 0) ? ZAMAN_ASIMI - 1 : 0);
  localparam logic [ADRES_BIT-1:0] HIZA_MASKE =
    ~((ADRES_BIT'(1) << BLOK_BAYT_BIT) - ADRES_BIT'(1));

  typedef enum logic [1:0] {BOSTA, ISTEK, YANIT, TAMAM} durum_e;

  durum_e                durum_q, durum_d;
  logic [KB-1:0]         kelime_q, kelime_d;
  logic [ADRES_BIT-1:0]  taban_q, taban_d;
  logic [SB-1:0]         sayac_q, sayac_d;
  logic                  hata_q, hata_d;
  logic [BLOK_BIT-1:0]   blok_q, blok_d;
  logic                  zaman_doldu;

  assign zaman_doldu = (ZAMAN_ASIMI != 0) && (sayac_q == SAYAC_SON);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q  <= BOSTA;
      kelime_q <= '0;
      taban_q  <= '0;
      sayac_q  <= '0;
      hata_q   <= 1'b0;
      blok_q   <= '0;
    end else begin
      durum_q  <= durum_d;
      kelime_q <= kelime_d;
      taban_q  <= taban_d;
      sayac_q  <= sayac_d;
      hata_q   <= hata_d;
      blok_q   <= blok_d;
    end
  end

  // The wait counter defaults to zero so that every state change restarts it.
  always_comb begin
    durum_d  = durum_q;
    kelime_d = kelime_q;
    taban_d  = taban_q;
    sayac_d  = '0;
    hata_d   = hata_q;
    blok_d   = blok_q;
    unique case (durum_q)
      BOSTA: begin
        hata_d = 1'b0;
        if (bus.okuma_istek_gecerli_i) begin
          taban_d  = bus.okuma_istek_adres_i & HIZA_MASKE;
          kelime_d = '0;
          durum_d  = ISTEK;
        end
      end
      ISTEK: begin
        if (bus.bellek_istek_hazir_i) begin
          durum_d = YANIT;
        end else if (zaman_doldu) begin
          hata_d  = 1'b1;
          durum_d = TAMAM;
        end else begin
          sayac_d = sayac_q + SB'(1);
        end
      end
      YANIT: begin
        if (bus.bellek_veri_gecerli_i) begin
          for (int w = 0; w < BLOK_KELIME; w++) begin
            if (KB'(w) == kelime_q) begin
              blok_d[w*VERI_BIT +: VERI_BIT] = bus.bellek_veri_i;
            end
          end
          if (kelime_q == SON_KELIME) begin
            durum_d = TAMAM;
          end else begin
            kelime_d = kelime_q + KB'(1);
            durum_d  = ISTEK;
          end
        end else if (zaman_doldu) begin
          hata_d  = 1'b1;
          durum_d = TAMAM;
        end else begin
          sayac_d = sayac_q + SB'(1);
        end
      end
      TAMAM: begin
        hata_d  = 1'b0;
        durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  // Address is gated to zero outside ISTEK so idle/reset outputs read as 0.
  assign bus.bellek_istek_gecerli_o = (durum_q == ISTEK);
  assign bus.bellek_istek_adres_o   = (durum_q == ISTEK)
                                      ? taban_q + (ADRES_BIT'(kelime_q) << KELIME_BAYT_BIT)
                                      : '0;
  assign bus.okuma_istek_hazir_o    = (durum_q == TAMAM);
  assign bus.hata_o                 = (durum_q == TAMAM) && hata_q;
  assign bus.okuma_veri_blok_o      = blok_q;

endmodule

// File: tb/tb_buyruk_blok_doldurucu.sv
// Scoreboard bench for the refill engine: a memory model checks request addresses,
// a monitor pops expected blocks whenever okuma_istek_hazir_o pulses.
module tb_buyruk_blok_doldurucu;

  logic clk;
  logic rst_ni;

  buyruk_blok_doldurucu_if #(.ADRES_BIT(32), .VERI_BIT(32), .BLOK_KELIME(4)) bus ();

  buyruk_blok_doldurucu #(
    .ADRES_BIT(32), .VERI_BIT(32), .BLOK_KELIME(4), .ZAMAN_ASIMI(8)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] blok;
    logic         hata;
  } beklenen_t;

  typedef enum {M_BOS, M_ISTEK, M_YANIT} mdurum_e;

  beklenen_t   beklenenQ[$];
  logic [31:0] adresBekQ[$];
  logic [31:0] veriQ[$];

  int hataSay    = 0;
  int kontrolSay = 0;
  int maxStall   = 0;
  int dusurKelime = -1;
  bit sahteVeri  = 1'b0;

  task automatic checkOutput(input string ad, input logic [127:0] gercek,
                             input logic [127:0] beklenen);
    kontrolSay++;
    if (gercek !== beklenen) begin
      hataSay++;
      $display("[TB] FAIL %s: got %h expected %h", ad, gercek, beklenen);
    end
  endtask

  task automatic hazirla(input logic [31:0] taban, input logic [31:0] w0,
                         input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input int dusur);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      if (dusur < 0 || i <= dusur) adresBekQ.push_back(taban + 32'(i * 4));
      if (dusur < 0 || i < dusur)  veriQ.push_back(w[i]);
    end
  endtask

  task automatic beklenenEkle(input logic [127:0] blok, input logic hata);
    beklenen_t b;
    b.blok = blok;
    b.hata = hata;
    beklenenQ.push_back(b);
  endtask

  task automatic applyStimulus(input logic [31:0] adr, input bit degistir,
                               output int gecikme);
    bit bitti = 1'b0;
    @(negedge clk);
    bus.okuma_istek_gecerli_i = 1'b1;
    bus.okuma_istek_adres_i   = adr;
    gecikme = 0;
    for (int i = 0; i < 3000 && !bitti; i++) begin
      @(negedge clk);
      gecikme++;
      if (degistir && gecikme == 3) bus.okuma_istek_adres_i = ~adr;
      if (bus.okuma_istek_hazir_o) begin
        bus.okuma_istek_gecerli_i = 1'b0;
        bitti = 1'b1;
      end
    end
    if (!bitti) begin
      bus.okuma_istek_gecerli_i = 1'b0;
      checkOutput("hazir_zaman_asimi", 128'(bitti), 128'd1);
    end
  endtask

  // Memory model: one transaction at a time, optional random stalls, optional
  // dropped word and spurious read-data strobes outside the response window.
  initial begin
    mdurum_e     mDurum, bas;
    logic [31:0] adrTut;
    int          kalan;
    bit          vgVerildi;
    mDurum = M_BOS;
    adrTut = '0;
    kalan  = 0;
    bus.bellek_istek_hazir_i  = 1'b0;
    bus.bellek_veri_gecerli_i = 1'b0;
    bus.bellek_veri_i         = '0;
    forever begin
      @(negedge clk);
      bas       = mDurum;
      vgVerildi = 1'b0;
      bus.bellek_istek_hazir_i  = 1'b0;
      bus.bellek_veri_gecerli_i = 1'b0;
      if (!rst_ni) begin
        mDurum = M_BOS;
      end else begin
        if (mDurum == M_BOS && bus.bellek_istek_gecerli_o) begin
          adrTut = bus.bellek_istek_adres_o;
          if (adresBekQ.size() == 0)
            checkOutput("fazla_istek", 128'(adrTut), 128'hFFFF_FFFF_FFFF_FFFF);
          else
            checkOutput("bellek_adres", 128'(adrTut), 128'(adresBekQ.pop_front()));
          kalan  = $urandom_range(0, maxStall);
          mDurum = M_ISTEK;
        end else if (mDurum == M_ISTEK) begin
          checkOutput("stall_gecerli", 128'(bus.bellek_istek_gecerli_o), 128'd1);
          checkOutput("stall_adres", 128'(bus.bellek_istek_adres_o), 128'(adrTut));
        end
        if (mDurum == M_ISTEK) begin
          if (kalan == 0) begin
            bus.bellek_istek_hazir_i = 1'b1;
            kalan  = $urandom_range(0, maxStall);
            mDurum = M_YANIT;
          end else begin
            kalan--;
          end
        end else if (mDurum == M_YANIT) begin
          if (int'(adrTut[3:2]) == dusurKelime) begin
            mDurum = M_BOS;
          end else if (kalan == 0) begin
            bus.bellek_veri_gecerli_i = 1'b1;
            bus.bellek_veri_i = (veriQ.size() > 0) ? veriQ.pop_front() : 32'h0BAD_0BAD;
            vgVerildi = 1'b1;
            mDurum = M_BOS;
          end else begin
            kalan--;
          end
        end
        if (sahteVeri && bas != M_YANIT && !vgVerildi) begin
          bus.bellek_veri_gecerli_i = 1'b1;
          bus.bellek_veri_i         = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_ni && bus.okuma_istek_hazir_o) begin
      if (beklenenQ.size() == 0) begin
        checkOutput("beklenmeyen_hazir", 128'd1, 128'd0);
      end else begin
        beklenen_t b;
        b = beklenenQ.pop_front();
        checkOutput("blok", bus.okuma_veri_blok_o, b.blok);
        checkOutput("hata", 128'(bus.hata_o), 128'(b.hata));
      end
    end
    if (rst_ni && bus.hata_o && !bus.okuma_istek_hazir_o)
      checkOutput("hata_tek_basina", 128'(bus.hata_o), 128'd0);
  end

  initial begin
    int gecikme;
    int sayi;
    bit bulundu;
    rst_ni = 1'b0;
    bus.okuma_istek_gecerli_i = 1'b0;
    bus.okuma_istek_adres_i   = '0;
    #1;
    checkOutput("rst_blok", bus.okuma_veri_blok_o, 128'd0);
    checkOutput("rst_hazir", 128'(bus.okuma_istek_hazir_o), 128'd0);
    checkOutput("rst_hata", 128'(bus.hata_o), 128'd0);
    checkOutput("rst_gecerli", 128'(bus.bellek_istek_gecerli_o), 128'd0);
    checkOutput("rst_adres", 128'(bus.bellek_istek_adres_o), 128'd0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;

    // Zero-wait refill, minimum latency
    hazirla(32'h0000_1230, 32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, -1);
    beklenenEkle(128'hA0A0_0003_A0A0_0002_A0A0_0001_A0A0_0000, 1'b0);
    applyStimulus(32'h0000_1238, 1'b0, gecikme);
    checkOutput("gecikme_ilk", 128'(gecikme), 128'd9);
    repeat (3) @(negedge clk);

    // Random stalls plus a request address change mid-refill
    maxStall = 5;
    hazirla(32'h0000_2A10, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, -1);
    beklenenEkle(128'h4444_4444_3333_3333_2222_2222_1111_1111, 1'b0);
    applyStimulus(32'h0000_2A14, 1'b1, gecikme);
    hazirla(32'h0000_5550, 32'h5050_0000, 32'h5050_1111, 32'h5050_2222, 32'h5050_3333, -1);
    beklenenEkle(128'h5050_3333_5050_2222_5050_1111_5050_0000, 1'b0);
    applyStimulus(32'h0000_555C, 1'b0, gecikme);
    maxStall = 0;
    repeat (3) @(negedge clk);

    // Top of address space with spurious read-data strobes
    sahteVeri = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("sahte_bosta", bus.okuma_veri_blok_o, 128'h5050_3333_5050_2222_5050_1111_5050_0000);
    hazirla(32'hFFFF_FFF0, 32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, -1);
    beklenenEkle(128'hCAFE_0003_CAFE_0002_CAFE_0001_CAFE_0000, 1'b0);
    applyStimulus(32'hFFFF_FFF4, 1'b0, gecikme);
    repeat (5) @(negedge clk);
    checkOutput("sahte_sonra", bus.okuma_veri_blok_o, 128'hCAFE_0003_CAFE_0002_CAFE_0001_CAFE_0000);
    sahteVeri = 1'b0;

    // Word 2 never answered: timeout keeps old slices 2 and 3
    dusurKelime = 2;
    hazirla(32'h0000_3000, 32'h7777_0000, 32'h7777_0001, 32'h0, 32'h0, 2);
    beklenenEkle(128'hCAFE_0003_CAFE_0002_7777_0001_7777_0000, 1'b1);
    applyStimulus(32'h0000_3008, 1'b0, gecikme);
    dusurKelime = -1;
    repeat (3) @(negedge clk);
    hazirla(32'h0000_3000, 32'h8888_0000, 32'h8888_0001, 32'h8888_0002, 32'h8888_0003, -1);
    beklenenEkle(128'h8888_0003_8888_0002_8888_0001_8888_0000, 1'b0);
    applyStimulus(32'h0000_3000, 1'b0, gecikme);
    repeat (3) @(negedge clk);

    // Reset while waiting for word 1 data
    dusurKelime = 1;
    hazirla(32'h0000_4000, 32'h9999_0000, 32'h0, 32'h0, 32'h0, 1);
    @(negedge clk);
    bus.okuma_istek_gecerli_i = 1'b1;
    bus.okuma_istek_adres_i   = 32'h0000_4008;
    bulundu = 1'b0;
    for (int i = 0; i < 200 && !bulundu; i++) begin
      @(negedge clk);
      if (bus.bellek_istek_gecerli_o && bus.bellek_istek_adres_o == 32'h0000_4004) bulundu = 1'b1;
    end
    checkOutput("kelime1_istek", 128'(bulundu), 128'd1);
    @(negedge clk);
    rst_ni = 1'b0;
    bus.okuma_istek_gecerli_i = 1'b0;
    #1;
    checkOutput("ara_rst_blok", bus.okuma_veri_blok_o, 128'd0);
    checkOutput("ara_rst_hazir", 128'(bus.okuma_istek_hazir_o), 128'd0);
    checkOutput("ara_rst_gecerli", 128'(bus.bellek_istek_gecerli_o), 128'd0);
    checkOutput("ara_rst_adres", 128'(bus.bellek_istek_adres_o), 128'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    dusurKelime = -1;
    sayi = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.okuma_istek_hazir_o) sayi++;
    end
    checkOutput("rst_sonrasi_hazir", 128'(sayi), 128'd0);
    hazirla(32'h0000_4000, 32'h6666_0000, 32'h6666_0001, 32'h6666_0002, 32'h6666_0003, -1);
    beklenenEkle(128'h6666_0003_6666_0002_6666_0001_6666_0000, 1'b0);
    applyStimulus(32'h0000_4004, 1'b0, gecikme);
    checkOutput("gecikme_rst_sonrasi", 128'(gecikme), 128'd9);

    // Back-to-back requests without a duplicate refill
    hazirla(32'h0000_0100, 32'h0100_0000, 32'h0100_0001, 32'h0100_0002, 32'h0100_0003, -1);
    beklenenEkle(128'h0100_0003_0100_0002_0100_0001_0100_0000, 1'b0);
    hazirla(32'h0000_0200, 32'h0200_0000, 32'h0200_0001, 32'h0200_0002, 32'h0200_0003, -1);
    beklenenEkle(128'h0200_0003_0200_0002_0200_0001_0200_0000, 1'b0);
    applyStimulus(32'h0000_0100, 1'b0, gecikme);
    checkOutput("gecikme_100", 128'(gecikme), 128'd9);
    applyStimulus(32'h0000_0200, 1'b0, gecikme);
    checkOutput("gecikme_200", 128'(gecikme), 128'd9);
    repeat (10) @(negedge clk);

    checkOutput("kalan_beklenen", 128'(beklenenQ.size()), 128'd0);
    checkOutput("kalan_adres", 128'(adresBekQ.size()), 128'd0);
    checkOutput("kalan_veri", 128'(veriQ.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", hataSay, kontrolSay);
    $finish;
  end

endmodule
